// File: rtl/y86_pkg.sv
// y86_pkg
//   Shared definitions for the Y86-64 decode/writeback slice: instruction
//   codes, register IDs, status bit positions, the D/E pipeline register
//   layout and small helpers used when filling it.
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // Register IDs
    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;

    // Status bit positions within {hlt, in_inst, in_mem}
    localparam int STAT_HLT = 2;
    localparam int STAT_INS = 1;
    localparam int STAT_ADR = 0;

    typedef logic [63:0] word_t;
    typedef logic [3:0]  reg_id_t;

    // D/E pipeline register contents
    typedef struct packed {
        logic    valid;
        logic [3:0] icode;
        logic [3:0] ifun;
        word_t   val_c;
        word_t   val_p;
        word_t   val_a;
        word_t   val_b;
        reg_id_t dst_e;
        reg_id_t dst_m;
        logic [2:0] stat;
    } de_reg_t;

    // Bubble contents; also the reset image of the D/E register.
    function automatic de_reg_t de_nop();
        de_reg_t r;
        r       = '0;
        r.icode = INOP;
        r.dst_e = RNONE;
        r.dst_m = RNONE;
        return r;
    endfunction

    // Fetch status with the invalid-instruction flag folded in for icodes
    // beyond the defined set; other status bits pass straight through.
    function automatic logic [2:0] stat_merge(input logic [2:0] stat_in,
                                              input logic [3:0] icode);
        logic [2:0] s;
        s           = '0;
        s[STAT_HLT] = stat_in[STAT_HLT];
        s[STAT_ADR] = stat_in[STAT_ADR];
        s[STAT_INS] = stat_in[STAT_INS] | (icode > IPOPQ);
        return s;
    endfunction

endpackage

// File: rtl/y86_regfile.sv
// y86_regfile
//   Y86-64 program register file: NREGS x 64-bit, two read ports, two write
//   ports (E and M), asynchronous active-low reset.
//   Ports:
//     clk, rst_n              clock, async active-low reset
//     src_a, src_b            read addresses (RNONE reads 0)
//     val_a, val_b            read data, bypassed from same-cycle writes
//     we_e, dst_e, wdata_e    write port E
//     we_m, dst_m, wdata_m    write port M (wins over E on the same register)
module y86_regfile
    import y86_pkg::*;
#(
    parameter logic [63:0] RSP_RESET = 64'd1016,
    parameter int          NREGS     = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  src_a,
    input  logic [3:0]  src_b,
    output logic [63:0] val_a,
    output logic [63:0] val_b,
    input  logic        we_e,
    input  logic [3:0]  dst_e,
    input  logic [63:0] wdata_e,
    input  logic        we_m,
    input  logic [3:0]  dst_m,
    input  logic [63:0] wdata_m
);

    logic [63:0] regs [NREGS];

    logic hit_e;
    logic hit_m;

    // A write is only real when enabled and aimed at an architectural register.
    assign hit_e = we_e && (dst_e != RNONE) && (int'(dst_e) < NREGS);
    assign hit_m = we_m && (dst_m != RNONE) && (int'(dst_m) < NREGS);

    // Port M is written after port E so its value survives a collision
    // (popq %rsp: the loaded value must beat the incremented stack pointer).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= (i == int'(RRSP)) ? RSP_RESET : 64'd0;
            end
        end else begin
            if (hit_e) regs[dst_e] <= wdata_e;
            if (hit_m) regs[dst_m] <= wdata_m;
        end
    end

    // Reads see this cycle's writes, with the same M-over-E priority, so the
    // captured operand equals the file contents just after the edge.
    always_comb begin
        val_a = '0;
        if (src_a != RNONE && int'(src_a) < NREGS) begin
            if (hit_m && dst_m == src_a)      val_a = wdata_m;
            else if (hit_e && dst_e == src_a) val_a = wdata_e;
            else                              val_a = regs[src_a];
        end
    end

    always_comb begin
        val_b = '0;
        if (src_b != RNONE && int'(src_b) < NREGS) begin
            if (hit_m && dst_m == src_b)      val_b = wdata_m;
            else if (hit_e && dst_e == src_b) val_b = wdata_e;
            else                              val_b = regs[src_b];
        end
    end

endmodule

// File: rtl/decode_regfile.sv
// decode_regfile
//   Y86-64 decode/writeback stage. Derives register specifiers from the
//   fetched instruction, reads operands from the program register file
//   (with same-cycle writeback bypass) and captures everything in the D/E
//   pipeline register.
//   Ports:
//     clk, rst_n                         clock, async active-low reset
//     in_valid, icode, ifun, rA, rB,
//     valC, valP, stat_in                fetch outputs
//     stall, bubble                      D/E register hold / nop insert
//     wbE_en, wbE_dst, wbE_val           writeback port E
//     wbM_en, wbM_dst, wbM_val           writeback port M (priority)
//     d_valid, d_icode, d_ifun, d_valC,
//     d_valP, d_valA, d_valB, d_dstE,
//     d_dstM, d_stat                     D/E register outputs
module decode_regfile
    import y86_pkg::*;
#(
    parameter logic [63:0] RSP_RESET = 64'd1016,
    parameter int          NREGS     = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [3:0]  icode,
    input  logic [3:0]  ifun,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic [63:0] valC,
    input  logic [63:0] valP,
    input  logic [2:0]  stat_in,
    input  logic        stall,
    input  logic        bubble,
    input  logic        wbE_en,
    input  logic [3:0]  wbE_dst,
    input  logic [63:0] wbE_val,
    input  logic        wbM_en,
    input  logic [3:0]  wbM_dst,
    input  logic [63:0] wbM_val,
    output logic        d_valid,
    output logic [3:0]  d_icode,
    output logic [3:0]  d_ifun,
    output logic [63:0] d_valC,
    output logic [63:0] d_valP,
    output logic [63:0] d_valA,
    output logic [63:0] d_valB,
    output logic [3:0]  d_dstE,
    output logic [3:0]  d_dstM,
    output logic [2:0]  d_stat
);

    reg_id_t src_a;
    reg_id_t src_b;
    reg_id_t dst_e;
    reg_id_t dst_m;
    word_t   rd_a;
    word_t   rd_b;

    de_reg_t de_p0;
    de_reg_t de_p1;

    // Register specifiers. cmovXX issues dstE = rB unconditionally; the
    // condition is evaluated in execute, which may cancel the write.
    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        dst_e = RNONE;
        dst_m = RNONE;

        case (icode)
            IRRMOVQ, IRMMOVQ, IOPQ, IPUSHQ: src_a = rA;
            IRET, IPOPQ:                    src_a = RRSP;
            default:                        src_a = RNONE;
        endcase

        case (icode)
            IRMMOVQ, IMRMOVQ, IOPQ:         src_b = rB;
            ICALL, IRET, IPUSHQ, IPOPQ:     src_b = RRSP;
            default:                        src_b = RNONE;
        endcase

        case (icode)
            IRRMOVQ, IIRMOVQ, IOPQ:         dst_e = rB;
            ICALL, IRET, IPUSHQ, IPOPQ:     dst_e = RRSP;
            default:                        dst_e = RNONE;
        endcase

        case (icode)
            IMRMOVQ, IPOPQ:                 dst_m = rA;
            default:                        dst_m = RNONE;
        endcase
    end

    y86_regfile #(
        .RSP_RESET (RSP_RESET),
        .NREGS     (NREGS)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .src_a   (src_a),
        .src_b   (src_b),
        .val_a   (rd_a),
        .val_b   (rd_b),
        .we_e    (wbE_en),
        .dst_e   (wbE_dst),
        .wdata_e (wbE_val),
        .we_m    (wbM_en),
        .dst_m   (wbM_dst),
        .wdata_m (wbM_val)
    );

    // ---- p0: decoded instruction, ready to be captured ----
    always_comb begin
        de_p0       = '0;
        de_p0.valid = 1'b1;
        de_p0.icode = icode;
        de_p0.ifun  = ifun;
        de_p0.val_c = valC;
        de_p0.val_p = valP;
        de_p0.val_a = rd_a;
        de_p0.val_b = rd_b;
        de_p0.dst_e = dst_e;
        de_p0.dst_m = dst_m;
        de_p0.stat  = stat_merge(stat_in, icode);
    end

    // ---- p1: D/E pipeline register ----
    // Bubble beats stall; an empty fetch slot becomes a bubble as well.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_p1 <= de_nop();
        end else if (bubble || (!stall && !in_valid)) begin
            de_p1 <= de_nop();
        end else if (!stall) begin
            de_p1 <= de_p0;
        end
    end

    assign d_valid = de_p1.valid;
    assign d_icode = de_p1.icode;
    assign d_ifun  = de_p1.ifun;
    assign d_valC  = de_p1.val_c;
    assign d_valP  = de_p1.val_p;
    assign d_valA  = de_p1.val_a;
    assign d_valB  = de_p1.val_b;
    assign d_dstE  = de_p1.dst_e;
    assign d_dstM  = de_p1.dst_m;
    assign d_stat  = de_p1.stat;

endmodule

// File: tb/tb_decode_regfile.sv
// tb_decode_regfile
//   Self-checking bench for decode_regfile: directed vector table, hand
//   sequences for stall / asynchronous reset, and randomized traffic checked
//   against a behavioural model of the register file and D/E register.
module tb_decode_regfile;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP;
    logic [2:0]  stat_in;
    logic        stall, bubble;
    logic        wbE_en;
    logic [3:0]  wbE_dst;
    logic [63:0] wbE_val;
    logic        wbM_en;
    logic [3:0]  wbM_dst;
    logic [63:0] wbM_val;
    logic        d_valid;
    logic [3:0]  d_icode, d_ifun;
    logic [63:0] d_valC, d_valP, d_valA, d_valB;
    logic [3:0]  d_dstE, d_dstM;
    logic [2:0]  d_stat;

    decode_regfile dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .icode(icode), .ifun(ifun),
        .rA(rA), .rB(rB), .valC(valC), .valP(valP), .stat_in(stat_in),
        .stall(stall), .bubble(bubble),
        .wbE_en(wbE_en), .wbE_dst(wbE_dst), .wbE_val(wbE_val),
        .wbM_en(wbM_en), .wbM_dst(wbM_dst), .wbM_val(wbM_val),
        .d_valid(d_valid), .d_icode(d_icode), .d_ifun(d_ifun), .d_valC(d_valC),
        .d_valP(d_valP), .d_valA(d_valA), .d_valB(d_valB), .d_dstE(d_dstE),
        .d_dstM(d_dstM), .d_stat(d_stat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic        valid;
        logic [3:0]  icode, ifun;
        logic [63:0] valC, valP, valA, valB;
        logic [3:0]  dstE, dstM;
        logic [2:0]  stat;
    } de_t;

    logic [63:0] mregs [15];
    de_t         mexp;

    function automatic de_t nop_image();
        de_t r;
        r.valid = 1'b0; r.icode = 4'h1; r.ifun = 4'h0;
        r.valC = 64'd0; r.valP = 64'd0; r.valA = 64'd0; r.valB = 64'd0;
        r.dstE = 4'hF; r.dstM = 4'hF; r.stat = 3'd0;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 15; i++) mregs[i] = (i == 4) ? 64'd1016 : 64'd0;
        mexp = nop_image();
    endtask

    // Operands captured by decode equal the file contents after this edge's
    // writes, so the model applies the writes first and then reads.
    task automatic model_step();
        logic [63:0] nr [15];
        logic [3:0]  sa, sb, de, dm;
        nr = mregs;
        if (wbE_en && wbE_dst != 4'hF) nr[wbE_dst] = wbE_val;
        if (wbM_en && wbM_dst != 4'hF) nr[wbM_dst] = wbM_val;
        if (bubble || (!stall && !in_valid)) begin
            mexp = nop_image();
        end else if (!stall) begin
            sa = (icode inside {4'h2, 4'h4, 4'h6, 4'hA}) ? rA :
                 (icode inside {4'h9, 4'hB}) ? 4'h4 : 4'hF;
            sb = (icode inside {4'h4, 4'h5, 4'h6}) ? rB :
                 (icode inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
            de = (icode inside {4'h2, 4'h3, 4'h6}) ? rB :
                 (icode inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
            dm = (icode inside {4'h5, 4'hB}) ? rA : 4'hF;
            mexp.valid = 1'b1;
            mexp.icode = icode;
            mexp.ifun  = ifun;
            mexp.valC  = valC;
            mexp.valP  = valP;
            mexp.valA  = (sa == 4'hF) ? 64'd0 : nr[sa];
            mexp.valB  = (sb == 4'hF) ? 64'd0 : nr[sb];
            mexp.dstE  = de;
            mexp.dstM  = dm;
            mexp.stat  = stat_in | ((icode > 4'hB) ? 3'b010 : 3'b000);
        end
        mregs = nr;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic compare_model(input string tag);
        chk({tag, ".valid"}, 64'(d_valid), 64'(mexp.valid));
        chk({tag, ".icode"}, 64'(d_icode), 64'(mexp.icode));
        chk({tag, ".dstE"},  64'(d_dstE),  64'(mexp.dstE));
        chk({tag, ".dstM"},  64'(d_dstM),  64'(mexp.dstM));
        chk({tag, ".stat"},  64'(d_stat),  64'(mexp.stat));
        if (mexp.valid) begin
            chk({tag, ".ifun"}, 64'(d_ifun), 64'(mexp.ifun));
            chk({tag, ".valC"}, d_valC, mexp.valC);
            chk({tag, ".valP"}, d_valP, mexp.valP);
            chk({tag, ".valA"}, d_valA, mexp.valA);
            chk({tag, ".valB"}, d_valB, mexp.valB);
        end
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; icode = 4'h1; ifun = 4'h0; rA = 4'hF; rB = 4'hF;
        valC = 64'd0; valP = 64'd0; stat_in = 3'd0; stall = 1'b0; bubble = 1'b0;
        wbE_en = 1'b0; wbE_dst = 4'hF; wbE_val = 64'd0;
        wbM_en = 1'b0; wbM_dst = 4'hF; wbM_val = 64'd0;
    endtask

    // Reads every register through opq and compares with the reset image.
    task automatic check_reset_regs(input string tag);
        for (int k = 0; k < 8; k++) begin
            idle_inputs();
            in_valid = 1'b1; icode = 4'h6;
            rA = 4'(2 * k); rB = (k == 7) ? 4'hF : 4'(2 * k + 1);
            cycle();
            chk($sformatf("%s.reg%0d", tag, 2 * k), d_valA, (2 * k == 4) ? 64'd1016 : 64'd0);
            chk($sformatf("%s.reg%0d", tag, 2 * k + 1), d_valB, 64'd0);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        iv;
        logic [3:0]  ic, ra, rb;
        logic [2:0]  st;
        logic        stl, bub;
        logic        we;
        logic [3:0]  de;
        logic [63:0] ve;
        logic        wm;
        logic [3:0]  dm;
        logic [63:0] vm;
        logic        xv;
        logic [3:0]  xi;
        logic [63:0] xa, xb;
        logic [3:0]  xe, xm;
        logic [2:0]  xs;
    } vec_t;

    localparam int NV = 14;
    vec_t tbl [NV];

    initial begin
        model_reset();
        idle_inputs();
        rst_n = 1'b0;

        tbl[0]  = '{1'b1, 4'h1, 4'hF, 4'hF, 3'd0, 1'b0, 1'b0, 1'b1, 4'h3, 64'h200, 1'b0, 4'hF, 64'h0,
                    1'b1, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF, 3'd0};
        tbl[1]  = '{1'b1, 4'h6, 4'h1, 4'h3, 3'd0, 1'b0, 1'b0, 1'b0, 4'hF, 64'h0, 1'b0, 4'hF, 64'h0,
                    1'b1, 4'h6, 64'h0, 64'h200, 4'h3, 4'hF, 3'd0};
        tbl[2]  = '{1'b1, 4'hA, 4'h3, 4'hF, 3'd0, 1'b0, 1'b0, 1'b0, 4'hF, 64'h0, 1'b0, 4'hF, 64'h0,
                    1'b1, 4'hA, 64'h200, 64'd1016, 4'h4, 4'hF, 3'd0};
        tbl[3]  = '{1'b1, 4'h6, 4'h1, 4'h2, 3'd0, 1'b0, 1'b0, 1'b0, 4'hF, 64'h0, 1'b1, 4'h1, 64'h55,
                    1'b1, 4'h6, 64'h55, 64'h0, 4'h2, 4'hF, 3'd0};
        tbl[4]  = '{1'b1, 4'h1, 4'hF, 4'hF, 3'd0, 1'b0, 1'b0, 1'b1, 4'h4, 64'h10, 1'b1, 4'h4, 64'h20,
                    1'b1, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF, 3'd0};
        tbl[5]  = '{1'b1, 4'hB, 4'h5, 4'hF, 3'd0, 1'b0, 1'b0, 1'b0, 4'hF, 64'h0, 1'b0, 4'hF, 64'h0,
                    1'b1, 4'hB, 64'h20, 64'h20, 4'h4, 4'h5, 3'd0};
        tbl[6]  = '{1'b1, 4'hC, 4'h1, 4'h2, 3'd0, 1'b0, 1'b0, 1'b0, 4'hF, 64'h0, 1'b0, 4'hF, 64'h0,
                    1'b1, 4'hC, 64'h0, 64'h0, 4'hF, 4'hF, 3'b010};
        tbl[7]  = '{1'b0, 4'h6, 4'h1, 4'h2, 3'd0, 1'b0, 1'b0, 1'b0, 4'hF, 64'h0, 1'b0, 4'hF, 64'h0,
                    1'b0, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF, 3'd0};
        tbl[8]  = '{1'b1, 4'h6, 4'h1, 4'h2, 3'd0, 1'b1, 1'b1, 1'b0, 4'hF, 64'h0, 1'b0, 4'hF, 64'h0,
                    1'b0, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF, 3'd0};
        tbl[9]  = '{1'b1, 4'h0, 4'hF, 4'hF, 3'b100, 1'b0, 1'b0, 1'b0, 4'hF, 64'h0, 1'b0, 4'hF, 64'h0,
                    1'b1, 4'h0, 64'h0, 64'h0, 4'hF, 4'hF, 3'b100};
        tbl[10] = '{1'b1, 4'h6, 4'hF, 4'h0, 3'd0, 1'b0, 1'b0, 1'b1, 4'hF, 64'hDEAD, 1'b0, 4'hF, 64'h0,
                    1'b1, 4'h6, 64'h0, 64'h0, 4'h0, 4'hF, 3'd0};
        tbl[11] = '{1'b1, 4'h2, 4'h1, 4'h7, 3'd0, 1'b0, 1'b0, 1'b1, 4'h1, 64'h77, 1'b1, 4'h1, 64'h99,
                    1'b1, 4'h2, 64'h99, 64'h0, 4'h7, 4'hF, 3'd0};
        tbl[12] = '{1'b1, 4'h5, 4'h6, 4'h1, 3'd0, 1'b0, 1'b0, 1'b0, 4'hF, 64'h0, 1'b0, 4'hF, 64'h0,
                    1'b1, 4'h5, 64'h0, 64'h99, 4'hF, 4'h6, 3'd0};
        tbl[13] = '{1'b1, 4'h8, 4'hF, 4'hF, 3'd0, 1'b0, 1'b0, 1'b0, 4'hF, 64'h0, 1'b0, 4'hF, 64'h0,
                    1'b1, 4'h8, 64'h0, 64'h20, 4'h4, 4'hF, 3'd0};

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid", 64'(d_valid), 64'd0);
        chk("rst.icode", 64'(d_icode), 64'h1);
        chk("rst.ifun",  64'(d_ifun),  64'h0);
        chk("rst.valC",  d_valC, 64'd0);
        chk("rst.valP",  d_valP, 64'd0);
        chk("rst.valA",  d_valA, 64'd0);
        chk("rst.valB",  d_valB, 64'd0);
        chk("rst.dstE",  64'(d_dstE), 64'hF);
        chk("rst.dstM",  64'(d_dstM), 64'hF);
        chk("rst.stat",  64'(d_stat), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_reset_regs("rstregs");

        // ---- directed table ----
        for (int i = 0; i < NV; i++) begin
            idle_inputs();
            in_valid = tbl[i].iv; icode = tbl[i].ic; rA = tbl[i].ra; rB = tbl[i].rb;
            ifun = 4'(i); valC = 64'h1000 + 64'(i); valP = 64'h2000 + 64'(i);
            stat_in = tbl[i].st; stall = tbl[i].stl; bubble = tbl[i].bub;
            wbE_en = tbl[i].we; wbE_dst = tbl[i].de; wbE_val = tbl[i].ve;
            wbM_en = tbl[i].wm; wbM_dst = tbl[i].dm; wbM_val = tbl[i].vm;
            cycle();
            chk($sformatf("vec%0d.valid", i), 64'(d_valid), 64'(tbl[i].xv));
            chk($sformatf("vec%0d.icode", i), 64'(d_icode), 64'(tbl[i].xi));
            chk($sformatf("vec%0d.valA", i),  d_valA, tbl[i].xa);
            chk($sformatf("vec%0d.valB", i),  d_valB, tbl[i].xb);
            chk($sformatf("vec%0d.dstE", i),  64'(d_dstE), 64'(tbl[i].xe));
            chk($sformatf("vec%0d.dstM", i),  64'(d_dstM), 64'(tbl[i].xm));
            chk($sformatf("vec%0d.stat", i),  64'(d_stat), 64'(tbl[i].xs));
            if (tbl[i].xv) begin
                chk($sformatf("vec%0d.ifun", i), 64'(d_ifun), 64'(i));
                chk($sformatf("vec%0d.valC", i), d_valC, 64'h1000 + 64'(i));
                chk($sformatf("vec%0d.valP", i), d_valP, 64'h2000 + 64'(i));
            end
        end

        // ---- asynchronous reset mid-stream: in-flight write is discarded ----
        idle_inputs();
        in_valid = 1'b1; icode = 4'h6; rA = 4'h3; rB = 4'h1;
        wbE_en = 1'b1; wbE_dst = 4'h3; wbE_val = 64'hABC;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.valid", 64'(d_valid), 64'd0);
        chk("arst.icode", 64'(d_icode), 64'h1);
        chk("arst.dstE",  64'(d_dstE), 64'hF);
        chk("arst.valA",  d_valA, 64'd0);
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check_reset_regs("arstregs");

        // ---- stall holds D/E for 3 cycles while writes continue ----
        idle_inputs();
        in_valid = 1'b1; icode = 4'h6; ifun = 4'h2; rA = 4'h4; rB = 4'h4;
        valC = 64'h1234; valP = 64'h5678;
        cycle();
        chk("stl0.valA", d_valA, 64'd1016);
        chk("stl0.valB", d_valB, 64'd1016);
        for (int c = 0; c < 3; c++) begin
            idle_inputs();
            in_valid = 1'b1; icode = 4'h3; ifun = 4'h0; rA = 4'h1; rB = 4'h2;
            valC = 64'hFFFF; valP = 64'hEEEE; stall = 1'b1;
            wbE_en = 1'b1; wbE_dst = 4'h4; wbE_val = 64'h99 + 64'(c);
            cycle();
            chk($sformatf("stl%0d.valid", c + 1), 64'(d_valid), 64'd1);
            chk($sformatf("stl%0d.icode", c + 1), 64'(d_icode), 64'h6);
            chk($sformatf("stl%0d.ifun", c + 1),  64'(d_ifun),  64'h2);
            chk($sformatf("stl%0d.valC", c + 1),  d_valC, 64'h1234);
            chk($sformatf("stl%0d.valP", c + 1),  d_valP, 64'h5678);
            chk($sformatf("stl%0d.valA", c + 1),  d_valA, 64'd1016);
            chk($sformatf("stl%0d.valB", c + 1),  d_valB, 64'd1016);
            chk($sformatf("stl%0d.dstE", c + 1),  64'(d_dstE), 64'h4);
            chk($sformatf("stl%0d.dstM", c + 1),  64'(d_dstM), 64'hF);
        end
        idle_inputs();
        in_valid = 1'b1; icode = 4'h9;
        cycle();
        chk("unstl.valA", d_valA, 64'h9B);
        chk("unstl.valB", d_valB, 64'h9B);
        chk("unstl.dstE", 64'(d_dstE), 64'h4);
        chk("unstl.dstM", 64'(d_dstM), 64'hF);

        // ---- randomized traffic against the model ----
        for (int n = 0; n < 400; n++) begin
            in_valid = ($urandom_range(7) != 0);
            icode    = 4'($urandom_range(15));
            ifun     = 4'($urandom_range(15));
            rA       = 4'($urandom_range(15));
            rB       = 4'($urandom_range(15));
            valC     = {$urandom, $urandom};
            valP     = {$urandom, $urandom};
            stat_in  = ($urandom_range(9) == 0) ? 3'($urandom_range(7)) : 3'd0;
            stall    = ($urandom_range(7) == 0);
            bubble   = ($urandom_range(9) == 0);
            wbE_en   = $urandom_range(1) == 1;
            wbE_dst  = ($urandom_range(3) == 0) ? 4'h4 : 4'($urandom_range(15));
            wbE_val  = {$urandom, $urandom};
            wbM_en   = $urandom_range(1) == 1;
            wbM_dst  = ($urandom_range(3) == 0) ? wbE_dst : 4'($urandom_range(15));
            wbM_val  = {$urandom, $urandom};
            cycle();
            compare_model($sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
